// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: turns a show-ahead FIFO read port into a valid/ready
// stream through a 2-entry skid buffer, with optional fixed-length bursts.
module fifo_stream_reader #(
  parameter int DSIZE     = 16,
  parameter int DEPTH     = 128,
  parameter int BURST_LEN = 8
) (
  input  logic                     rd_clk,
  input  logic                     rd_resetn,
  input  logic [DSIZE-1:0]         fifo_data_i,
  input  logic                     fifo_empty_i,
  input  logic [$clog2(DEPTH):0]   fifo_occupied_i,
  output logic                     fifo_rd_req_o,
  input  logic                     burst_en_i,
  output logic [DSIZE-1:0]         m_data_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     busy_o
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("fifo_stream_reader: DEPTH must be a power of 2 and BURST_LEN in 1..DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_BURST  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [1:0]       count_q, count_d;
  logic [DSIZE-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             last0_q, last0_d, last1_q, last1_d;

  logic pop_ok;
  logic burst_end;
  logic rd_req;
  logic xfer;
  logic wr_slot1;

  // State, burst counter and buffer registers.
  always_ff @(posedge rd_clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      count_q <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      count_q <= count_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
    end
  end

  // Next-state logic; burst counter clears on entry so it never wraps.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!burst_en_i) begin
          state_d = S_STREAM;
        end else if (fifo_occupied_i >= OW'(BURST_LEN)) begin
          state_d = S_BURST;
          bcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (burst_en_i) state_d = S_IDLE;
        else            state_d = S_STREAM;
      end
      S_BURST: begin
        if (rd_req) begin
          bcnt_d = bcnt_q + BW'(1);
          if (burst_end) state_d = S_IDLE;
          else           state_d = S_BURST;
        end else begin
          state_d = S_BURST;
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // State-decoded pop permission and end-of-burst flag.
  always_comb begin
    pop_ok    = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      S_STREAM: pop_ok = 1'b1;
      S_BURST: begin
        pop_ok    = 1'b1;
        burst_end = (bcnt_q == BW'(BURST_LEN - 1));
      end
      default: begin
        pop_ok    = 1'b0;
        burst_end = 1'b0;
      end
    endcase
  end

  // No path from m_ready_i into the pop request.
  assign rd_req    = pop_ok & ~fifo_empty_i & ~count_q[1];
  assign xfer      = m_valid_o & m_ready_i;
  assign wr_slot1  = (count_q == 2'd1) & ~xfer;

  // Skid buffer: shift on transfer, vacated slots zeroed so idle outputs read 0.
  always_comb begin
    data0_d = data0_q;
    last0_d = last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    if (xfer) begin
      data0_d = data1_q;
      last0_d = last1_q;
      data1_d = '0;
      last1_d = 1'b0;
    end else begin
      data0_d = data0_q;
      last0_d = last0_q;
    end
    if (rd_req) begin
      if (wr_slot1) begin
        data1_d = fifo_data_i;
        last1_d = burst_end;
      end else begin
        data0_d = fifo_data_i;
        last0_d = burst_end;
      end
    end else begin
      count_d = count_q;
    end
    count_d = count_q + {1'b0, rd_req} - {1'b0, xfer};
  end

  assign fifo_rd_req_o = rd_req;
  assign m_valid_o     = (count_q != 2'd0);
  assign m_data_o      = data0_q;
  assign m_last_o      = last0_q;
  assign busy_o        = (state_q != S_IDLE) | m_valid_o;

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the dual-clock FIFO: sits entirely in the read clock domain and turns the FIFO's request/empty read port into a valid/ready stream toward downstream logic. It owns `rd_req` generation, holds popped words in a 2-entry buffer so backpressure never loses data, and has a burst mode that releases exactly BURST_LEN words, with the final word flagged by `m_last_o`, once enough words are present.

## Interface
- DSIZE, 16: data width; matches the FIFO.
- DEPTH, 128: FIFO depth, power of 2; sets the occupancy width OW = $clog2(DEPTH)+1.
- BURST_LEN, 8: words per burst; legal range 1..DEPTH; elaboration error otherwise.

Clocking and reset: one clock; reset is asynchronous and active-low.

- rd_clk  in  1  read-domain clock; the only clock of the block.
- rd_resetn  in  1  asynchronous active-low reset.
- fifo_data_i  in  DSIZE  FIFO head word; show-ahead, valid whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO read-domain empty flag.
- fifo_occupied_i  in  OW  FIFO read-domain occupancy.
- fifo_rd_req_o  out  1  pop request; the FIFO pops on the same rd_clk edge.
- burst_en_i  in  1  1 = burst mode, 0 = stream mode; sampled only in IDLE.
- m_data_o  out  DSIZE  output word.
- m_last_o  out  1  last word of a burst; always 0 in stream mode.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream accept.
- busy_o  out  1  1 when state≠IDLE or the buffer count≠0.

## Operation
- Buffer: 2-entry register FIFO of {last, data} with count 0..2.
  - m_valid_o = (count≠0).
  - Head is presented on m_data_o/m_last_o.
  - A transfer occurs when m_valid_o & m_ready_i.
- Pop rule: fifo_rd_req_o = pop_allowed_by_state & !fifo_empty_i & (count<2). It is combinational from registered state and FIFO flags only, with no path from m_ready_i.
- On a pop, fifo_data_i is written into the buffer on the same edge.
- A simultaneous pop and transfer leaves count unchanged. Data order is strictly preserved.
- States:
  - IDLE: no pops.
    - burst_en_i=0 → STREAM.
    - burst_en_i=1 and fifo_occupied_i ≥ BURST_LEN → BURST, with burst counter cleared to 0.
    - Otherwise remain in IDLE.
  - STREAM: pops are allowed per the pop rule; last=0 on every word. burst_en_i=1 → IDLE. A pop in that same cycle still completes.
  - BURST: pops are allowed per the pop rule.
    - Each pop increments the burst counter.
    - The pop taken with counter = BURST_LEN-1 stores last=1 and moves the state to IDLE.
    - burst_en_i is ignored until the state returns to IDLE.
    - If fifo_empty_i asserts mid-burst, popping stalls; the burst is never truncated or aborted.
- Occupancy: fifo_occupied_i is a lagging, conservative count (it can only under-report), so a burst entered on it normally completes without stalls. The empty guard is still mandatory.
- Reset (any cycle, including mid-burst or with a full buffer):
  - state returns to IDLE; count=0; burst counter=0; buffered words are discarded.
  - Outputs: m_valid_o=0, m_last_o=0, m_data_o=0, fifo_rd_req_o=0, busy_o=0.

## Timing
- Pop to output: a word popped at edge N is visible with m_valid_o=1 in cycle N+1.
- Mode entry costs one cycle in IDLE with no pop.
  - Stream-mode latency from reset release, with a non-empty FIFO: first pop at the 2nd edge; m_valid_o at the 3rd.
- Back-to-back burst: after the last pop, one IDLE cycle follows before the next burst's first pop.
- Throughput: 1 word/cycle sustained with m_ready_i=1 (count holds at 1).
- Backpressure:
  - With m_ready_i=0, at most 2 words are popped, then fifo_rd_req_o=0.
  - m_data_o and m_last_o are held stable while m_valid_o=1 & m_ready_i=0.
- Burst counter width is $clog2(BURST_LEN+1). It never wraps, because it is cleared on entry to BURST.

## Test plan
- Stream drain: reset; FIFO holds 0x0001..0x0010, burst_en_i=0, m_ready_i=1 → 16 words out in order on consecutive cycles; m_last_o always 0; fifo_rd_req_o never asserted while fifo_empty_i=1.
- Backpressure: stream mode, m_ready_i=0 for 10 cycles with 5 words available → exactly 2 pops; m_data_o=0x0001 held stable; on release, words 1..5 delivered in order with no loss or duplication.
- Burst gating: BURST_LEN=8, burst_en_i=1, occupancy rises 0→7 → no pops; at 8 → exactly 8 pops, m_last_o=1 only on the 8th word, then an IDLE cycle. With 20 words present, two full bursts run and 4 words remain.
- Mid-burst underrun: force fifo_empty_i=1 after 3 pops of a burst → popping stalls and state stays BURST; on refill, 5 more pops, and the last=1 word is the 8th.
- Mode toggle: raise burst_en_i during STREAM while a pop occurs → that popped word is delivered; IDLE is entered the next cycle; burst_en_i toggled mid-burst has no effect.
- Async reset: assert rd_resetn mid-burst with count=2, between clock edges → all outputs 0 immediately; after release, state is IDLE and busy_o=0.
